// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: fetch FSM state encoding, cache line
// geometry and the HALT opcode value used by decode.
package cpu_pkg;

   localparam int LINE_WORDS = 4;
   localparam int WORD_W     = 16;
   localparam int LINE_W     = LINE_WORDS * WORD_W;

   localparam logic [3:0] OPC_HALT = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_COMPARE_TAG = 2'd1,
      ST_ALLOCATE    = 2'd2,
      ST_HALTED      = 2'd3
   } fetch_state_t;

   // Base word address of the 4-word line containing addr.
   function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_icache_if.sv
// Line-fill bus between the fetch stage and instruction memory.
//   mem_re      : fill request, held until mem_rdy
//   mem_addr    : line base word address of the request
//   mem_rdy     : fill data valid this cycle
//   mem_rd_data : whole line, word k at bits [16k+15:16k]
// master = fetch stage, slave = memory.
interface ifetch_icache_if;
   import cpu_pkg::*;

   logic              mem_re;
   logic [WORD_W-1:0] mem_addr;
   logic              mem_rdy;
   logic [LINE_W-1:0] mem_rd_data;

   modport master (output mem_re, output mem_addr, input mem_rdy, input mem_rd_data);
   modport slave  (input mem_re, input mem_addr, output mem_rdy, output mem_rd_data);

endinterface

// File: rtl/ifetch_icache_array.sv
// Direct-mapped instruction cache storage: per-line tag, data and valid bit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears valid only)
//   rd_idx              : lookup index; rd_tag/rd_valid/rd_line are combinational
//   wr_en, wr_idx       : line install strobe and index
//   wr_tag, wr_line     : tag and data written on install
//   wr_valid            : valid bit written on install
//   clr_all             : invalidate every line
module icache_array
   import cpu_pkg::*;
#(
   parameter  int NUM_LINES = 16,
   localparam int IW        = $clog2(NUM_LINES),
   localparam int TAG_W     = WORD_W - IW - 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IW-1:0]     rd_idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic [LINE_W-1:0] rd_line,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              wr_valid,
   input  logic              clr_all
);

   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_W-1:0]    data_mem [NUM_LINES];
   logic [NUM_LINES-1:0] valid;

   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];
   assign rd_valid = valid[rd_idx];

   // Tag/data need no reset: a line is only trusted through its valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (clr_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= wr_valid;
      end
   end

endmodule

// File: rtl/ifetch_icache.sv
// Instruction fetch stage with a direct-mapped read-only instruction cache.
// Holds the PC, looks up the cache, fills missing 4-word lines over the mem
// bus and hands one registered 16-bit instruction per cycle to decode.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall_in                 : hold fetch outputs and PC
//   redirect, redirect_pc    : taken branch/CALL/RET target (word address)
//   halt                     : HALT seen by decode; stops fetch until reset
//   if_instr, if_pc_plus1    : registered instruction and its PC + 1
//   if_valid                 : if_instr/if_pc_plus1 meaningful
//   halted, icache_miss      : fetch stopped / line fill in progress
//   mem                      : line-fill bus (master side)
//   flush                    : invalidate all lines (only with ICACHE_FLUSH_EN)
// Optional feature macro: ICACHE_FLUSH_EN.
module ifetch_icache
   import cpu_pkg::*;
#(
   parameter int          NUM_LINES = 16,
   parameter logic [15:0] RESET_PC  = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              halt,
   output logic [WORD_W-1:0] if_instr,
   output logic [WORD_W-1:0] if_pc_plus1,
   output logic              if_valid,
   output logic              halted,
   output logic              icache_miss,
   ifetch_icache_if.master   mem
`ifdef ICACHE_FLUSH_EN
   ,
   input  logic              flush
`endif
);

   // state          | meaning
   // ST_IDLE        | one settling cycle after reset
   // ST_COMPARE_TAG | lookup at pc, deliver on hit
   // ST_ALLOCATE    | waiting for the line fill (mem_re held)
   // ST_HALTED      | fetch stopped until reset

   localparam int IW    = $clog2(NUM_LINES);
   localparam int TAG_W = WORD_W - IW - 2;

   fetch_state_t      state, state_n;
   logic [WORD_W-1:0] pc, pc_n;
   logic [WORD_W-1:0] instr_n, ppl_n;
   logic              valid_n;
   logic              mem_re_q, mem_re_n;
   logic [WORD_W-1:0] mem_addr_q, mem_addr_n;
   logic              pend_redir, pend_redir_n;
   logic [WORD_W-1:0] pend_pc, pend_pc_n;
   logic              pend_halt, pend_halt_n;
   logic              fill_kill, fill_kill_n;

   logic              flush_i;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic [LINE_W-1:0] rd_line;
   logic              wr_en, wr_valid, clr_all;
   logic              hit;
   logic [WORD_W-1:0] hit_word;
   logic              halt_on_fill;

`ifdef ICACHE_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   icache_array #(.NUM_LINES(NUM_LINES)) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (pc[IW+1:2]),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_line  (rd_line),
      .wr_en    (wr_en),
      .wr_idx   (mem_addr_q[IW+1:2]),
      .wr_tag   (mem_addr_q[WORD_W-1:IW+2]),
      .wr_line  (mem.mem_rd_data),
      .wr_valid (wr_valid),
      .clr_all  (clr_all)
   );

   // A flush in the lookup cycle forces a miss even on a matching line.
   assign hit      = rd_valid && (rd_tag == pc[WORD_W-1:IW+2]) && !flush_i;
   assign hit_word = rd_line[{pc[1:0], 4'b0000} +: WORD_W];

   assign halted       = (state == ST_HALTED);
   assign icache_miss  = (state == ST_ALLOCATE);
   assign mem.mem_re   = mem_re_q;
   assign mem.mem_addr = mem_addr_q;

   // A redirect seen up to and including the fill cycle squashes any halt.
   assign halt_on_fill = !redirect && !pend_redir && (pend_halt || halt);

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      instr_n      = if_instr;
      ppl_n        = if_pc_plus1;
      valid_n      = if_valid;
      mem_re_n     = mem_re_q;
      mem_addr_n   = mem_addr_q;
      pend_redir_n = pend_redir;
      pend_pc_n    = pend_pc;
      pend_halt_n  = pend_halt;
      fill_kill_n  = fill_kill;
      wr_en        = 1'b0;
      wr_valid     = 1'b0;
      clr_all      = 1'b0;

      unique case (state)
         ST_IDLE: begin
            valid_n = 1'b0;
            clr_all = flush_i;
            state_n = ST_COMPARE_TAG;
         end

         ST_COMPARE_TAG: begin
            clr_all = flush_i;
            if (redirect) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
            end else if (stall_in) begin
               // everything holds
            end else if (halt) begin
               valid_n = 1'b0;
               state_n = ST_HALTED;
            end else if (hit) begin
               instr_n = hit_word;
               ppl_n   = pc + 16'd1;
               valid_n = 1'b1;
               pc_n    = pc + 16'd1;
            end else begin
               valid_n    = 1'b0;
               mem_re_n   = 1'b1;
               mem_addr_n = line_base(pc);
               state_n    = ST_ALLOCATE;
            end
         end

         ST_ALLOCATE: begin
            valid_n = 1'b0;
            if (redirect) begin
               pend_redir_n = 1'b1;
               pend_pc_n    = redirect_pc;
               pend_halt_n  = 1'b0;
            end else if (halt) begin
               pend_halt_n = 1'b1;
            end
            if (flush_i) begin
               fill_kill_n = 1'b1;
            end
            if (mem.mem_rdy) begin
               wr_en        = 1'b1;
               wr_valid     = !(fill_kill || flush_i);
               mem_re_n     = 1'b0;
               pend_redir_n = 1'b0;
               pend_halt_n  = 1'b0;
               fill_kill_n  = 1'b0;
               if (redirect) begin
                  pc_n = redirect_pc;
               end else if (pend_redir) begin
                  pc_n = pend_pc;
               end
               state_n = halt_on_fill ? ST_HALTED : ST_COMPARE_TAG;
            end
         end

         ST_HALTED: begin
            valid_n  = 1'b0;
            mem_re_n = 1'b0;
         end

         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         if_instr    <= '0;
         if_pc_plus1 <= '0;
         if_valid    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         pend_redir  <= 1'b0;
         pend_pc     <= '0;
         pend_halt   <= 1'b0;
         fill_kill   <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         if_instr    <= instr_n;
         if_pc_plus1 <= ppl_n;
         if_valid    <= valid_n;
         mem_re_q    <= mem_re_n;
         mem_addr_q  <= mem_addr_n;
         pend_redir  <= pend_redir_n;
         pend_pc     <= pend_pc_n;
         pend_halt   <= pend_halt_n;
         fill_kill   <= fill_kill_n;
      end
   end

endmodule

// File: tb/tb_ifetch_icache.sv
// Directed self-checking bench for ifetch_icache. A small memory model answers
// line fills a fixed number of cycles after it sees mem_re. Flush scenarios
// are compiled in only when ICACHE_FLUSH_EN is defined.
module tb_ifetch_icache;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic [15:0] if_instr;
   logic [15:0] if_pc_plus1;
   logic        if_valid;
   logic        halted;
   logic        icache_miss;
`ifdef ICACHE_FLUSH_EN
   logic        flush = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic        model_en   = 1'b1;
   logic        model_rdy  = 1'b0;
   logic [63:0] model_data = '0;
   int          model_cnt  = 0;
   logic        man_rdy    = 1'b0;
   logic [63:0] man_data   = '0;

   ifetch_icache_if bus ();

   assign bus.mem_rdy     = model_rdy | man_rdy;
   assign bus.mem_rd_data = man_rdy ? man_data : model_data;

   ifetch_icache #(.NUM_LINES(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_in    (stall_in),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .if_instr    (if_instr),
      .if_pc_plus1 (if_pc_plus1),
      .if_valid    (if_valid),
      .halted      (halted),
      .icache_miss (icache_miss),
      .mem         (bus)
`ifdef ICACHE_FLUSH_EN
      ,
      .flush       (flush)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] m(input logic [15:0] a);
      return (a * 16'd7) ^ 16'hB00B;
   endfunction

   function automatic logic [63:0] line_of(input logic [15:0] b);
      return {m(b + 16'd3), m(b + 16'd2), m(b + 16'd1), m(b)};
   endfunction

   // Memory: counts LAT falling edges with mem_re high, then returns the line
   // for one cycle.
   always @(negedge clk) begin
      if (!model_en) begin
         model_rdy = 1'b0;
         model_cnt = 0;
      end else if (model_rdy) begin
         model_rdy = 1'b0;
         model_cnt = 0;
      end else if (bus.mem_re) begin
         if (model_cnt == LAT) begin
            model_rdy  = 1'b1;
            model_data = line_of(bus.mem_addr);
         end else begin
            model_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input logic [15:0] exp_instr,
                             input logic [15:0] exp_ppl);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!if_valid && n < 40);
      chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
      chk({tag, "_instr"}, {16'd0, if_instr}, {16'd0, exp_instr});
      chk({tag, "_ppl"}, {16'd0, if_pc_plus1}, {16'd0, exp_ppl});
   endtask

   task automatic do_redirect(input logic [15:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      tick();
      redirect    = 1'b0;
   endtask

   initial begin
      // cold start: edge 0 in reset
      tick();
      rst = 1'b0;
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", {16'd0, if_instr}, 32'd0);
      chk("rst_ppl", {16'd0, if_pc_plus1}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_miss", {31'd0, icache_miss}, 32'd0);
      chk("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
      chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
      tick();                                              // edge 1
      chk("c1_mem_re", {31'd0, bus.mem_re}, 32'd0);
      tick();                                              // edge 2
      chk("c2_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("c2_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
      chk("c2_miss", {31'd0, icache_miss}, 32'd1);
      tick(); tick(); tick();                              // edge 5
      chk("c5_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("c5_valid", {31'd0, if_valid}, 32'd0);
      tick();                                              // edge 6
      chk("c6_mem_re", {31'd0, bus.mem_re}, 32'd0);
      chk("c6_valid", {31'd0, if_valid}, 32'd0);
      tick();                                              // edge 7
      chk("c7_valid", {31'd0, if_valid}, 32'd1);
      chk("c7_instr", {16'd0, if_instr}, {16'd0, m(16'h0000)});
      chk("c7_ppl", {16'd0, if_pc_plus1}, 32'h0001);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("stream_instr", {16'd0, if_instr}, {16'd0, m(16'(k))});
         chk("stream_ppl", {16'd0, if_pc_plus1}, 32'(k + 1));
         chk("stream_valid", {31'd0, if_valid}, 32'd1);
      end
      tick();                                              // edge 11
      chk("c11_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("c11_mem_addr", {16'd0, bus.mem_addr}, 32'h0004);
      chk("c11_valid", {31'd0, if_valid}, 32'd0);
      wait_valid("line4", m(16'h0004), 16'h0005);
      tick();
      chk("w5_instr", {16'd0, if_instr}, {16'd0, m(16'h0005)});

      // stall for three cycles during hits
      stall_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_instr", {16'd0, if_instr}, {16'd0, m(16'h0005)});
         chk("stall_ppl", {16'd0, if_pc_plus1}, 32'h0006);
      end
      stall_in = 1'b0;
      tick();
      chk("resume6_instr", {16'd0, if_instr}, {16'd0, m(16'h0006)});
      chk("resume6_ppl", {16'd0, if_pc_plus1}, 32'h0007);
      tick();
      chk("resume7_instr", {16'd0, if_instr}, {16'd0, m(16'h0007)});

      // redirect in COMPARE_TAG
      do_redirect(16'h0042);
      chk("redir_valid", {31'd0, if_valid}, 32'd0);
      tick();
      chk("redir_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("redir_mem_addr", {16'd0, bus.mem_addr}, 32'h0040);
      wait_valid("redir42", m(16'h0042), 16'h0043);
      tick();
      chk("redir43_instr", {16'd0, if_instr}, {16'd0, m(16'h0043)});
      tick();
      chk("miss44_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("miss44_mem_addr", {16'd0, bus.mem_addr}, 32'h0044);

      // same redirect while the 0x44 fill is outstanding
      do_redirect(16'h0042);
      chk("alloc_redir_re", {31'd0, bus.mem_re}, 32'd1);
      chk("alloc_redir_addr", {16'd0, bus.mem_addr}, 32'h0044);
      wait_valid("alloc_redir42", m(16'h0042), 16'h0043);
      tick();
      chk("alloc_redir43", {16'd0, if_instr}, {16'd0, m(16'h0043)});
      tick();
      chk("fill44_hit_instr", {16'd0, if_instr}, {16'd0, m(16'h0044)});
      chk("fill44_hit_valid", {31'd0, if_valid}, 32'd1);
      chk("fill44_hit_re", {31'd0, bus.mem_re}, 32'd0);

      // conflict on index 0: 0x0000 vs 0x0040
      do_redirect(16'h0000);
      tick();
      chk("conf0_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
      chk("conf0_mem_re", {31'd0, bus.mem_re}, 32'd1);
      wait_valid("conf0", m(16'h0000), 16'h0001);
      do_redirect(16'h0040);
      tick();
      chk("conf40_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("conf40_mem_addr", {16'd0, bus.mem_addr}, 32'h0040);
      wait_valid("conf40", m(16'h0040), 16'h0041);
      do_redirect(16'h0000);
      tick();
      chk("conf0b_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("conf0b_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
      wait_valid("conf0b", m(16'h0000), 16'h0001);

      // PC wrap at 0xFFFF
      do_redirect(16'hFFFF);
      tick();
      chk("wrap_mem_addr", {16'd0, bus.mem_addr}, 32'hFFFC);
      wait_valid("wrapFFFF", m(16'hFFFF), 16'h0000);
      tick();
      chk("wrap0_instr", {16'd0, if_instr}, {16'd0, m(16'h0000)});
      chk("wrap0_ppl", {16'd0, if_pc_plus1}, 32'h0001);

      // halt together with redirect: redirect wins
      halt        = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0002;
      tick();
      halt        = 1'b0;
      redirect    = 1'b0;
      chk("hr_halted", {31'd0, halted}, 32'd0);
      chk("hr_valid", {31'd0, if_valid}, 32'd0);
      tick();
      chk("hr_instr", {16'd0, if_instr}, {16'd0, m(16'h0002)});
      chk("hr_halted2", {31'd0, halted}, 32'd0);

      // halt with a hit pending
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, if_valid}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 16'h0000;
      stall_in    = 1'b1;
      tick();
      redirect = 1'b0;
      stall_in = 1'b0;
      tick();
      chk("halt_stays", {31'd0, halted}, 32'd1);
      chk("halt_valid2", {31'd0, if_valid}, 32'd0);
      chk("halt_mem_re", {31'd0, bus.mem_re}, 32'd0);

      // reset mid-fill, then a stale mem_rdy
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_halted", {31'd0, halted}, 32'd0);
      tick();
      tick();
      chk("rst2_mem_re", {31'd0, bus.mem_re}, 32'd1);
      tick();
      rst      = 1'b1;
      model_en = 1'b0;
      tick();
      rst      = 1'b0;
      chk("midfill_mem_re", {31'd0, bus.mem_re}, 32'd0);
      chk("midfill_miss", {31'd0, icache_miss}, 32'd0);
      chk("midfill_addr", {16'd0, bus.mem_addr}, 32'h0000);
      man_rdy  = 1'b1;
      man_data = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      man_rdy = 1'b0;
      chk("stale_miss", {31'd0, icache_miss}, 32'd0);
      chk("stale_valid", {31'd0, if_valid}, 32'd0);
      tick();
      chk("stale_refetch_re", {31'd0, bus.mem_re}, 32'd1);
      chk("stale_refetch_addr", {16'd0, bus.mem_addr}, 32'h0000);
      model_en = 1'b1;
      wait_valid("after_stale", m(16'h0000), 16'h0001);

`ifdef ICACHE_FLUSH_EN
      // flush in COMPARE_TAG: the lookup in that cycle misses
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_mem_re", {31'd0, bus.mem_re}, 32'd1);
      chk("flush_mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
      wait_valid("flush_refill", m(16'h0001), 16'h0002);
      tick();
      tick();
      tick();
      chk("flush4_mem_addr", {16'd0, bus.mem_addr}, 32'h0004);
      // flush during ALLOCATE: line lands invalid, lookup misses again
      flush = 1'b1;
      tick();
      flush = 1'b0;
      begin
         int n;
         n = 0;
         while (bus.mem_re && n < 40) begin
            tick();
            n++;
         end
         chk("kill_fill_done", {31'd0, bus.mem_re}, 32'd0);
      end
      tick();
      chk("kill_remiss_re", {31'd0, bus.mem_re}, 32'd1);
      chk("kill_remiss_addr", {16'd0, bus.mem_addr}, 32'h0004);
      wait_valid("kill_refill", m(16'h0004), 16'h0005);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
